load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   MEM-stage load/store unit between the EX/MEM pipeline register and data_memory.
//   Converts byte-addressed RV64 loads/stores (B/H/W/D, signed/unsigned) into whole-doubleword accesses.
//   Merges sub-word store bytes by read-modify-write, and extracts and extends load bytes.
//   Splits accesses that cross a doubleword boundary into two memory cycles and stalls upstream meanwhile.
// PARAMETERS
//   DATA_WIDTH  64  doubleword width. Fixed at 64.
//   ADDR_WIDTH  10  doubleword index width, matching data_memory. Byte address is ADDR_WIDTH+3 bits.
// PORTS
//   clk             in   1             rising-edge clock
//   reset           in   1             asynchronous, active-low reset
//   req_valid       in   1             request present
//   req_ready       out  1             request accepted when req_valid & req_ready
//   is_load         in   1             load request
//   is_store        in   1             store request
//   funct3          in   3             RV64 size/sign code: [1:0] = log2(bytes); [2] = unsigned load
//   byte_addr       in   ADDR_WIDTH+3  byte address, little-endian
//   store_data      in   64            store value, right-aligned
//   resp_valid      out  1             one-cycle completion pulse, loads and stores
//   load_data       out  64            extended load result, held until the next response
//   mem_addr        out  ADDR_WIDTH    to data_memory addr
//   mem_write_data  out  64            to data_memory write_data
//   mem_write       out  1             to data_memory mem_write
//   mem_read        out  1             to data_memory mem_read
//   mem_read_data   in   64            from data_memory read_data (combinational read)
// BEHAVIOUR
//   Reset (reset==0, async) values:
//     - state=IDLE; resp_valid=0; load_data=0; low-part hold register=0; latched request=0.
//     - mem_write, mem_read and mem_addr are 0 while in reset.
//   Definitions: off=byte_addr[2:0]; nbytes=1<<funct3[1:0]; idx=byte_addr[ADDR_WIDTH+2:3].
//   Two states, IDLE and SECOND.
//   IDLE (req_ready=1):
//     - Accept when req_valid=1.
//     - Request with is_load=is_store=0: ignored. No access, no response.
//     - Illegal request: is_load&is_store, load funct3=111, or store funct3[2]=1.
//       No mem_read/mem_write; next cycle resp_valid=1 with load_data=0.
//     - Single access (off+nbytes<=8): mem_addr=idx, mem_read=1.
//       Store: mem_write=1, mem_write_data = mem_read_data with bytes off..off+nbytes-1 replaced by store_data.
//       Load: extract those bytes, zero- or sign-extend to 64 per funct3[2], register into load_data.
//       resp_valid=1 on the next cycle. Back-to-back accepts every cycle are allowed.
//     - Split access (off+nbytes>8):
//       Latch the request. Handle bytes off..7 of idx: store merges and writes them; load captures them in the hold register.
//       Go to SECOND.
//   SECOND (req_ready=0; req_valid ignored):
//     - mem_addr=(idx+1) mod 2^ADDR_WIDTH; wraps to 0 past the top word.
//     - Handle the remaining off+nbytes-8 bytes at byte 0 of the word.
//       Store: merge and write. Load: concatenate with the hold register, extend, register into load_data.
//     - Next cycle resp_valid=1; return to IDLE.
//   Latency from accept to resp_valid: 1 cycle single, 2 cycles split. req_ready is low exactly 1 cycle per split.
//   Reset asserted in SECOND: abort. The second-word write is never issued; no resp_valid.
//   load_data changes only with a load response or an illegal-request response (set to 0); stores leave it unchanged.
// STRUCTURE
//   riscv_mem_pkg:
//     - funct3 size encodings: SZ_B/SZ_H/SZ_W/SZ_D.
//     - lsu_state_t enum {IDLE, SECOND}.
//     - constants DWORD_BYTES=8, DATA_WIDTH=64.
//   Sub-module lsu_align, combinational:
//     - store merge: old word, data, off, nbytes, part -> new word.
//     - load extract/extend: word(s), off, funct3 -> 64-bit result.
//   The top holds the FSM, request latch, hold register and output registers.
// TESTING
//   1. SD 0x1122334455667788 @0x10, then LD @0x10 -> resp_valid 1 cycle after each; load_data=0x1122334455667788.
//   2. SB 0xAB @0x13, then LD @0x10 -> 0x11223344AB667788.
//      LB @0x13 -> 0xFFFFFFFFFFFFFFAB; LBU @0x13 -> 0x00000000000000AB.
//   3. SW 0xDEADBEEF @0x0E -> two writes (word1 bytes6-7=EF,BE; word2 bytes0-1=AD,DE); req_ready low 1 cycle.
//      LW @0x0E -> 0xFFFFFFFFDEADBEEF at cycle 2.
//   4. LD @byte 0x1FFC (ADDR_WIDTH=10, top word) -> second access mem_addr=0.
//      load_data = {mem[0][31:0], mem[1023][63:32]}.
//   5. Split SD @0x0C with reset pulsed low during SECOND -> word2 unchanged; resp_valid=0; req_ready=1 after reset release.
//   6. Load funct3=111, and is_load=is_store=1 -> no mem_read/mem_write; resp_valid=1; load_data=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the MEM-stage load/store path.
package riscv_mem_pkg;

  localparam int unsigned DATA_WIDTH  = 64;
  localparam int unsigned DWORD_BYTES = 8;
  localparam int unsigned OFF_WIDTH   = 3;
  // Wide enough for off + nbytes, which reaches 15 on a crossing doubleword.
  localparam int unsigned CNT_WIDTH   = 4;

  // funct3[1:0] size encodings.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_t;

  // Request fields that must survive into the second word of a split access.
  typedef struct packed {
    logic                  is_load;
    logic [2:0]            funct3;
    logic [OFF_WIDTH-1:0]  off;
    logic [DATA_WIDTH-1:0] store_data;
  } lsu_req_t;

  function automatic logic [CNT_WIDTH-1:0] size_bytes(input logic [1:0] sz);
    return CNT_WIDTH'(1) << sz;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data_memory signals of the load/store unit.
interface load_store_unit_if
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                        req_valid;
  logic                        req_ready;
  logic                        is_load;
  logic                        is_store;
  logic [2:0]                  funct3;
  logic [ADDR_WIDTH+2:0]       byte_addr;
  logic [DATA_WIDTH-1:0]       store_data;
  logic                        resp_valid;
  logic [DATA_WIDTH-1:0]       load_data;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]       mem_write_data;
  logic                        mem_write;
  logic                        mem_read;
  logic [DATA_WIDTH-1:0]       mem_read_data;

  // Environment side: pipeline plus data_memory.
  modport master (
    output req_valid, is_load, is_store, funct3, byte_addr, store_data, mem_read_data,
    input  req_ready, resp_valid, load_data, mem_addr, mem_write_data, mem_write, mem_read
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, is_load, is_store, funct3, byte_addr, store_data, mem_read_data,
    output req_ready, resp_valid, load_data, mem_addr, mem_write_data, mem_write, mem_read
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane datapath: sub-word store merge and load extract/extend.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [OFF_WIDTH-1:0]  off,
  input  logic [CNT_WIDTH-1:0]  nbytes,
  input  logic                  part,
  output logic [DATA_WIDTH-1:0] merged,
  input  logic [DATA_WIDTH-1:0] lo_word,
  input  logic [DATA_WIDTH-1:0] hi_word,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] load_result
);

  localparam int unsigned KW = CNT_WIDTH + 1;

  logic [DATA_WIDTH-1:0] raw;

  // Lane i takes store byte k = i + 8*part - off whenever k < nbytes; underflow lands above nbytes.
  always_comb begin
    logic [KW-1:0] k;
    merged = old_word;
    k      = '0;
    for (int i = 0; i < DWORD_BYTES; i++) begin
      k = KW'(i) + (part ? KW'(DWORD_BYTES) : KW'(0)) - KW'(off);
      if (k < {1'b0, nbytes}) begin
        merged[8*i +: 8] = store_data[8*k[2:0] +: 8];
      end
    end
  end

  // Right-align the addressed bytes across the word pair, then zero- or sign-extend.
  always_comb begin
    raw         = DATA_WIDTH'({hi_word, lo_word} >> {off, 3'b000});
    load_result = raw;
    case (funct3[1:0])
      SZ_B:    load_result = funct3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_H:    load_result = funct3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    load_result = funct3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: load_result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: doubleword-aligned read-modify-write with split handling.
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  lsu_state_t            state;
  lsu_state_t            state_next;
  lsu_req_t              req_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  resp_valid_q;

  logic [OFF_WIDTH-1:0]  off;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0]  nbytes;
  logic [CNT_WIDTH-1:0]  end_byte;
  logic                  active;
  logic                  illegal;
  logic                  split;
  logic                  legal;

  logic [OFF_WIDTH-1:0]  a_off;
  logic [2:0]            a_funct3;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] a_lo;
  logic [DATA_WIDTH-1:0] a_hi;
  logic                  a_part;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] load_result;

  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic                  mem_read_c;
  logic                  mem_write_c;

  // Incoming request decode.
  assign off      = bus.byte_addr[OFF_WIDTH-1:0];
  assign idx      = bus.byte_addr[ADDR_WIDTH+OFF_WIDTH-1:OFF_WIDTH];
  assign nbytes   = size_bytes(bus.funct3[1:0]);
  assign end_byte = CNT_WIDTH'(off) + nbytes;
  assign active   = (state == IDLE) && bus.req_valid && (bus.is_load || bus.is_store);
  assign illegal  = (bus.is_load && bus.is_store) ||
                    (bus.is_load && (bus.funct3 == 3'b111)) ||
                    (bus.is_store && bus.funct3[2]);
  assign split    = end_byte > CNT_WIDTH'(DWORD_BYTES);
  assign legal    = active && !illegal;

  // Datapath operands come from the live request in IDLE and from the latch in SECOND.
  always_comb begin
    a_off    = off;
    a_funct3 = bus.funct3;
    a_data   = bus.store_data;
    a_lo     = bus.mem_read_data;
    a_hi     = '0;
    a_part   = 1'b0;
    if (state == SECOND) begin
      a_off    = req_q.off;
      a_funct3 = req_q.funct3;
      a_data   = req_q.store_data;
      a_lo     = hold_q;
      a_hi     = bus.mem_read_data;
      a_part   = 1'b1;
    end
  end

  lsu_align u_align (
    .old_word    (bus.mem_read_data),
    .store_data  (a_data),
    .off         (a_off),
    .nbytes      (size_bytes(a_funct3[1:0])),
    .part        (a_part),
    .merged      (merged),
    .lo_word     (a_lo),
    .hi_word     (a_hi),
    .funct3      (a_funct3),
    .load_result (load_result)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: a legal crossing access spends one extra cycle in SECOND.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (legal && split) state_next = SECOND;
      SECOND:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes; forced quiet while reset is asserted so an aborted split never writes.
  always_comb begin
    mem_addr_c  = '0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (legal) begin
            mem_addr_c  = idx;
            mem_read_c  = 1'b1;
            mem_write_c = bus.is_store;
          end
        end
        SECOND: begin
          mem_addr_c  = idx_q + ADDR_WIDTH'(1);
          mem_read_c  = 1'b1;
          mem_write_c = !req_q.is_load;
        end
        default: ;
      endcase
    end
  end

  // Request latch, low-word hold and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      load_data_q  <= '0;
      hold_q       <= '0;
      req_q        <= '0;
      idx_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (state == SECOND) begin
        resp_valid_q <= 1'b1;
        if (req_q.is_load) load_data_q <= load_result;
      end else if (active) begin
        if (illegal) begin
          resp_valid_q <= 1'b1;
          load_data_q  <= '0;
        end else if (split) begin
          req_q <= '{is_load: bus.is_load, funct3: bus.funct3, off: off, store_data: bus.store_data};
          idx_q <= idx;
          if (bus.is_load) hold_q <= bus.mem_read_data;
        end else begin
          resp_valid_q <= 1'b1;
          if (bus.is_load) load_data_q <= load_result;
        end
      end
    end
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.load_data      = load_data_q;
  assign bus.mem_addr       = mem_addr_c;
  assign bus.mem_read       = mem_read_c;
  assign bus.mem_write      = mem_write_c;
  assign bus.mem_write_data = merged;

endmodule
